// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional FAST_MUL_EN: multiplies resolve at accept through a combinational multiplier.
module muldiv_unit #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_funct3,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int unsigned CNT_W = $clog2(XLEN + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   state_t              state;
   logic [2:0]          funct3;
   logic [TAG_W-1:0]    tag;
   logic                sign_a, sign_b;
   logic [XLEN-1:0]     abs_a, abs_b, quo;
   logic [XLEN:0]       rem;
   logic [2*XLEN-1:0]   prod;
   logic [CNT_W-1:0]    cnt;

   logic                is_div, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
   logic [XLEN-1:0]     abs_a_in, abs_b_in, spec_res;
   logic [XLEN:0]       mul_sum;
   logic [XLEN+1:0]     div_shift;
   logic                div_ge;
   logic [2*XLEN-1:0]   prod_fix;
   logic [XLEN-1:0]     quo_fix, rem_fix, fix_res;

   // Request decode: operand signedness and the divide cases resolved at accept
   always_comb begin
      is_div   = in_funct3[2];
      a_signed = is_div ? !in_funct3[0] : (in_funct3 != 3'b011);
      b_signed = is_div ? !in_funct3[0] : !in_funct3[1];
      a_neg    = a_signed & in_a[XLEN-1];
      b_neg    = b_signed & in_b[XLEN-1];
      abs_a_in = a_neg ? -in_a : in_a;
      abs_b_in = b_neg ? -in_b : in_b;
      div_zero = is_div && (in_b == '0);
      div_ovf  = is_div && !in_funct3[0] && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
      if (div_zero) spec_res = in_funct3[1] ? in_a : '1;
      else          spec_res = in_funct3[1] ? '0 : in_a;
   end

   // One radix-2 step of each datapath plus the sign fixup of the final values
   always_comb begin
      mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? abs_a : '0)};
      div_shift = {rem, quo[XLEN-1]};
      div_ge    = div_shift >= {2'b00, abs_b};
      prod_fix  = (sign_a ^ sign_b) ? -prod : prod;
      quo_fix   = (sign_a ^ sign_b) ? -quo : quo;
      rem_fix   = sign_a ? -rem[XLEN-1:0] : rem[XLEN-1:0];
      if (funct3[2])                fix_res = funct3[1] ? rem_fix : quo_fix;
      else if (funct3[1:0] == 2'b00) fix_res = prod_fix[XLEN-1:0];
      else                          fix_res = prod_fix[2*XLEN-1:XLEN];
   end

`ifdef FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   logic [XLEN-1:0]   fast_res;

   // Sign- or zero-extend by one bit so a single signed multiplier covers all variants
   always_comb begin
      fast_prod = (2*XLEN)'($signed({a_signed & in_a[XLEN-1], in_a}) *
                            $signed({b_signed & in_b[XLEN-1], in_b}));
      fast_res  = (in_funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_tag    <= '0;
         busy       <= 1'b0;
         funct3     <= '0;
         tag        <= '0;
         sign_a     <= 1'b0;
         sign_b     <= 1'b0;
         abs_a      <= '0;
         abs_b      <= '0;
         quo        <= '0;
         rem        <= '0;
         prod       <= '0;
         cnt        <= '0;
      end else if (flush) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  funct3   <= in_funct3;
                  tag      <= in_tag;
                  sign_a   <= a_neg;
                  sign_b   <= b_neg;
                  abs_a    <= abs_a_in;
                  abs_b    <= abs_b_in;
                  prod     <= {{XLEN{1'b0}}, abs_b_in};
                  quo      <= abs_a_in;
                  rem      <= '0;
                  cnt      <= CNT_W'(XLEN);
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (div_zero || div_ovf) begin
                     state      <= DONE;
                     out_valid  <= 1'b1;
                     out_result <= spec_res;
                     out_tag    <= in_tag;
                  end
`ifdef FAST_MUL_EN
                  else if (!is_div) begin
                     state      <= DONE;
                     out_valid  <= 1'b1;
                     out_result <= fast_res;
                     out_tag    <= in_tag;
                  end
`endif
                  else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (funct3[2]) begin
                  quo <= {quo[XLEN-2:0], div_ge};
                  rem <= div_ge ? (XLEN+1)'(div_shift - {2'b00, abs_b}) : (XLEN+1)'(div_shift);
               end else begin
                  prod <= {mul_sum, prod[XLEN-1:1]};
               end
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= FIXUP;
            end
            FIXUP: begin
               out_result <= fix_res;
               out_tag    <= tag;
               out_valid  <= 1'b1;
               state      <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit (XLEN=32) against a plain-arithmetic model.
// Honours FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned TAG_W = 5;
   localparam int unsigned NORM_LAT = XLEN + 2;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_funct3;
   logic [XLEN-1:0]  in_a, in_b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_result;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   int n_tests = 0;
   int n_fail  = 0;

   muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   // Architectural RV32M result
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [63:0]        up;
      logic signed [63:0] sp;
      int                 sa, sb;
      bit                 ovf;
      sa  = $signed(a);
      sb  = $signed(b);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'b000: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
         3'b001: begin sp = 64'(sa) * 64'(sb); return sp[63:32]; end
         3'b010: begin sp = 64'(sa) * $signed({32'b0, b}); return sp[63:32]; end
         3'b011: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
         3'b100: begin if (b == 0) return 32'hFFFF_FFFF; if (ovf) return a; return 32'(sa / sb); end
         3'b101: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
         3'b110: begin if (b == 0) return a; if (ovf) return 32'h0; return 32'(sa % sb); end
         default: begin if (b == 0) return a; return a % b; end
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3[2] && (b == 0)) return 1;
      if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef FAST_MUL_EN
      if (!f3[2]) return 1;
`endif
      return NORM_LAT;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   // Issue one request from IDLE, wait for its result, then consume it; lat counts from the accept edge
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t,
                        output logic [31:0] res, output logic [4:0] rt, output int lat);
      in_funct3 = f3; in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      res = out_result;
      rt  = out_tag;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_funct3 = '0; in_a = '0; in_b = '0; in_tag = '0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_tests++; if (out_result !== '0) begin n_fail++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
      n_tests++; if (out_tag !== '0) begin n_fail++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [2:0]  f3 [12];
      logic [31:0] va [12], vb [12], ve [12];
      logic [31:0] res;
      logic [4:0]  rt, t;
      int          lat, elat;
      f3 = '{3'b000, 3'b011, 3'b001, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111, 3'b101, 3'b110, 3'b100, 3'b110};
      va = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
             32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      vb = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      ve = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
             32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
      for (int i = 0; i < 12; i++) begin
         t = 5'(i + 3);
         elat = ref_latency(f3[i], va[i], vb[i]);
         do_op(f3[i], va[i], vb[i], t, res, rt, lat);
         n_tests++; if (res !== ve[i]) begin n_fail++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, ve[i]); end
         n_tests++; if (rt !== t) begin n_fail++; $display("FAIL directed_tag[%0d]: got %h expected %h", i, rt, t); end
         n_tests++; if (lat != elat) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, elat); end
      end
   endtask

   task automatic test_random();
      logic [2:0]  f3;
      logic [31:0] a, b, res;
      logic [4:0]  rt, t;
      int          lat;
      for (int i = 0; i < 60; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = pick_operand();
         b  = pick_operand();
         t  = 5'($urandom_range(0, 31));
         n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL random_ready[%0d]: got %b expected 1", i, in_ready); end
         do_op(f3, a, b, t, res, rt, lat);
         n_tests++;
         if (res !== ref_model(f3, a, b) || rt !== t || lat != ref_latency(f3, a, b)) begin
            n_fail++;
            $display("FAIL random_op[%0d] f3=%b a=%h b=%h: got res=%h tag=%h lat=%0d expected res=%h tag=%h lat=%0d",
                     i, f3, a, b, res, rt, lat, ref_model(f3, a, b), t, ref_latency(f3, a, b));
         end
      end
   endtask

   task automatic test_backpressure();
      int wait_cnt = 0;
      in_funct3 = 3'b101; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd9; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      while (!out_valid && wait_cnt < 200) begin @(posedge clk); #1; wait_cnt++; end
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_rise: got %b expected 1", out_valid); end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         n_tests++;
         if (out_valid !== 1'b1 || out_result !== 32'd14 || out_tag !== 5'd9 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got v=%b r=%h t=%h rdy=%b busy=%b expected v=1 r=0000000e t=09 rdy=0 busy=1",
                     c, out_valid, out_result, out_tag, in_ready, busy);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy: got %b expected 0", busy); end
   endtask

   task automatic test_flush();
      bit seen = 1'b0;
      in_funct3 = 3'b100; in_a = 32'($urandom); in_b = 32'd7; in_tag = 5'd4; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: got %b expected 1", busy); end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_idle: got busy=%b rdy=%b v=%b expected busy=0 rdy=1 v=0", busy, in_ready, out_valid);
      end
      repeat (50) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
      n_tests++; if (seen) begin n_fail++; $display("FAIL flush_no_result: got out_valid=1 expected never"); end
      // Request coinciding with flush in IDLE must be dropped
      in_funct3 = 3'b101; in_a = 32'd9; in_b = 32'd0; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_blocks_accept: got busy=%b rdy=%b v=%b expected busy=0 rdy=1 v=0", busy, in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      in_funct3 = 3'b000; in_a = 32'($urandom); in_b = 32'($urandom); in_tag = 5'd17; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
`ifndef FAST_MUL_EN
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
`endif
      reset_n = 1'b0;
      #2;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0 || out_tag !== '0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_async: got rdy=%b v=%b r=%h t=%h busy=%b expected rdy=1 v=0 r=0 t=0 busy=0",
                  in_ready, out_valid, out_result, out_tag, busy);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (40) begin @(posedge clk); #1; if (out_valid || busy) seen = 1'b1; end
      n_tests++; if (seen) begin n_fail++; $display("FAIL midreset_no_resume: got activity expected idle"); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res;
      logic [4:0]  rt;
      int          lat;
      // Divide then multiply immediately after the previous handshake
      do_op(3'b110, 32'hFFFF_FF9C, 32'd7, 5'd30, res, rt, lat);
      n_tests++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL b2b_rem: got %h expected fffffffe", res); end
      do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd31, res, rt, lat);
      n_tests++; if (res !== 32'h4000_0000 || rt !== 5'd31) begin n_fail++; $display("FAIL b2b_mulh: got %h/%h expected 40000000/1f", res, rt); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
